// File: rtl/mbz_nxm_ctl.sv
// MBOX non-existent-memory controller: times out unanswered memory requests,
// plays a synthetic acknowledge sequence and records the first failing request.
module mbz_nxm_ctl #(
    parameter int NCHAN   = 4,
    parameter int TMO_W   = 8,
    parameter int SEQ_LEN = 5,
    parameter int ADR_W   = 22,
    parameter int CNT_W   = 4,
    localparam int CH_W   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               MEM_START,
    input  logic [CH_W-1:0]    REQ_CHAN,
    input  logic               MEM_RD_RQ,
    input  logic [ADR_W-1:0]   REQ_ADR,
    input  logic               ACKN_PULSE,
    input  logic               PHASE_TICK,
    input  logic [TMO_W-1:0]   TMO_LIMIT,
    input  logic [NCHAN-1:0]   ERR_CLR,
    input  logic               ERA_CLR,
    output logic               MEM_BUSY,
    output logic               NXM_FLG,
    output logic [SEQ_LEN-1:0] NXM_T,
    output logic               NXM_ACKN,
    output logic               NXM_DATA_VAL,
    output logic [NCHAN-1:0]   NXM_ERR,
    output logic               HOLD_ERA,
    output logic [ADR_W-1:0]   ERA_ADR,
    output logic [CH_W-1:0]    ERA_CHAN,
    output logic               ERA_WRITE,
    output logic [CNT_W-1:0]   NXM_COUNT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_NXM
    } state_e;

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [CH_W-1:0]    chan_q, chan_d;
    logic               rd_q, rd_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [SEQ_LEN-1:0] nxm_t_q, nxm_t_d;
    logic [NCHAN-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               hold_q, hold_d;
    logic [ADR_W-1:0]   era_adr_q, era_adr_d;
    logic [CH_W-1:0]    era_chan_q, era_chan_d;
    logic               era_write_q, era_write_d;

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        chan_d      = chan_q;
        rd_d        = rd_q;
        adr_d       = adr_q;
        nxm_t_d     = '0;
        err_d       = err_q & ~ERR_CLR;
        count_d     = count_q;
        hold_d      = hold_q & ~ERA_CLR;
        era_adr_d   = era_adr_q;
        era_chan_d  = era_chan_q;
        era_write_d = era_write_q;

        case (state_q)
            ST_IDLE: begin
                if (MEM_START) begin
                    chan_d    = REQ_CHAN;
                    rd_d      = MEM_RD_RQ;
                    adr_d     = REQ_ADR;
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real acknowledge always beats a timeout landing on the same tick.
                if (ACKN_PULSE) begin
                    state_d = ST_IDLE;
                end else if (PHASE_TICK) begin
                    if (tmo_cnt_q == TMO_LIMIT) begin
                        state_d = ST_NXM;
                        nxm_t_d = SEQ_LEN'(1);
                        if (!hold_q) begin
                            era_adr_d   = adr_q;
                            era_chan_d  = chan_q;
                            era_write_d = !rd_q;
                            hold_d      = 1'b1;
                        end
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
            end
            ST_NXM: begin
                if (nxm_t_q[SEQ_LEN-1]) begin
                    state_d = ST_IDLE;
                end else begin
                    nxm_t_d = nxm_t_q << 1;
                    // Error and count become visible together with the synthetic acknowledge.
                    if (nxm_t_d[SEQ_LEN-1]) begin
                        if (int'(chan_q) < NCHAN) begin
                            err_d[chan_q] = 1'b1;
                        end
                        if (count_q != {CNT_W{1'b1}}) begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            tmo_cnt_q   <= '0;
            chan_q      <= '0;
            rd_q        <= 1'b0;
            adr_q       <= '0;
            nxm_t_q     <= '0;
            err_q       <= '0;
            count_q     <= '0;
            hold_q      <= 1'b0;
            era_adr_q   <= '0;
            era_chan_q  <= '0;
            era_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            chan_q      <= chan_d;
            rd_q        <= rd_d;
            adr_q       <= adr_d;
            nxm_t_q     <= nxm_t_d;
            err_q       <= err_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            era_adr_q   <= era_adr_d;
            era_chan_q  <= era_chan_d;
            era_write_q <= era_write_d;
        end
    end

    assign MEM_BUSY     = (state_q != ST_IDLE);
    assign NXM_FLG      = (state_q == ST_NXM);
    assign NXM_T        = nxm_t_q;
    assign NXM_ACKN     = (state_q == ST_NXM) && nxm_t_q[SEQ_LEN-1];
    assign NXM_DATA_VAL = NXM_ACKN && rd_q;
    assign NXM_ERR      = err_q;
    assign HOLD_ERA     = hold_q;
    assign ERA_ADR      = era_adr_q;
    assign ERA_CHAN     = era_chan_q;
    assign ERA_WRITE    = era_write_q;
    assign NXM_COUNT    = count_q;

endmodule

// File: doc/mbz_nxm_ctl.md
MBZ_NXM_CTL -- requirements
Module: mbz_nxm_ctl

Interface
REQ-001 Parameter NCHAN, 4, number of memory requestors (EBOX, CCA, channels); min 1.
REQ-002 Parameter TMO_W, 8, width of the NXM timeout counter and limit.
REQ-003 Parameter SEQ_LEN, 5, length of the synthetic NXM acknowledge sequence (T2..T6 at default); min 2.
REQ-004 Parameter ADR_W, 22, physical address width captured in the error address register.
REQ-005 Parameter CNT_W, 4, width of the saturating NXM event counter.
REQ-006 One clock; reset is synchronous and active-high: ports clk and RESET.
REQ-007 clk  in  1  MBOX clock; all state changes on rising edge.
REQ-008 RESET  in  1  synchronous active-high master reset.
REQ-009 MEM_START  in  1  start memory request; sampled only in IDLE.
REQ-010 REQ_CHAN  in  log2(NCHAN) (min 1)  requestor index, sampled with MEM_START.
REQ-011 MEM_RD_RQ  in  1  request is a read, sampled with MEM_START.
REQ-012 REQ_ADR  in  ADR_W  request address, sampled with MEM_START.
REQ-013 ACKN_PULSE  in  1  memory acknowledge.
REQ-014 PHASE_TICK  in  1  SBUS phase-change tick; advances timeout counter.
REQ-015 TMO_LIMIT  in  TMO_W  ticks to wait before declaring NXM.
REQ-016 ERR_CLR  in  NCHAN  per-channel NXM error clear.
REQ-017 ERA_CLR  in  1  releases error address register hold.
REQ-018 MEM_BUSY  out  1  request outstanding (state != IDLE).
REQ-019 NXM_FLG  out  1  high in NXM state.
REQ-020 NXM_T  out  SEQ_LEN  one-hot synthetic sequence step.
REQ-021 NXM_ACKN  out  1  one-cycle synthetic acknowledge.
REQ-022 NXM_DATA_VAL  out  1  one-cycle, with NXM_ACKN on reads only.
REQ-023 NXM_ERR  out  NCHAN  sticky per-channel NXM error.
REQ-024 HOLD_ERA  out  1  error address register frozen.
REQ-025 ERA_ADR / ERA_CHAN / ERA_WRITE  out  ADR_W / log2(NCHAN) / 1  captured failing request.
REQ-026 NXM_COUNT  out  CNT_W  saturating NXM event count.

Function
REQ-027 States IDLE, WAIT, NXM; encoding free.
REQ-028 IDLE & MEM_START: latch REQ_CHAN, MEM_RD_RQ, REQ_ADR; clear timeout counter; -> WAIT next cycle.
REQ-029 MEM_START outside IDLE is ignored; latched request unchanged.
REQ-030 WAIT & ACKN_PULSE: -> IDLE, no error; ACKN_PULSE wins over a same-cycle timeout.
REQ-031 WAIT & PHASE_TICK & !ACKN_PULSE: if counter == TMO_LIMIT -> NXM, else counter+1; counter never wraps (TMO_LIMIT = 0 times out on first tick).
REQ-032 ACKN_PULSE in IDLE or NXM is ignored.
REQ-033 NXM entry: NXM_T step 0 set; NXM_T shifts one position per cycle; NXM occupies exactly SEQ_LEN cycles.
REQ-034 Final NXM cycle: NXM_ACKN=1; NXM_DATA_VAL=latched read; NXM_ERR[chan] set; NXM_COUNT+1 saturating at 2^CNT_W-1; -> IDLE.
REQ-035 NXM entry with HOLD_ERA=0: capture ERA_ADR, ERA_CHAN, ERA_WRITE=!read; set HOLD_ERA; with HOLD_ERA=1 ERA unchanged (first error wins).
REQ-036 ERA_CLR clears HOLD_ERA; same-cycle capture wins over ERA_CLR.
REQ-037 ERR_CLR[i] clears NXM_ERR[i]; same-cycle set of bit i wins.
REQ-038 MEM_BUSY combinational from state; first IDLE cycle after NXM accepts MEM_START.

Reset
REQ-039 RESET, any state: next cycle state IDLE; all outputs 0, NXM_T=0, counters 0, ERA fields 0; mid-sequence NXM aborted without NXM_ACKN or error set.
REQ-040 RESET dominates all inputs in the same cycle.

Verification
REQ-041 TMO_LIMIT=3, read start chan 2 adr 0x1234, ACKN after 2 ticks -> IDLE, NXM_ERR=0, NXM_COUNT=0.
REQ-042 TMO_LIMIT=3, read chan 1, no ACKN, 4 ticks -> NXM, NXM_T 00001..10000 over 5 cycles, last cycle NXM_ACKN=1, NXM_DATA_VAL=1, NXM_ERR=0010, ERA_CHAN=1, HOLD_ERA=1.
REQ-043 Second NXM write chan 3 adr 0x0F00 while HOLD_ERA=1 -> NXM_ERR=1010, NXM_DATA_VAL=0, ERA still chan 1; ERA_CLR then third NXM -> ERA captures new request.
REQ-044 ACKN_PULSE and terminal PHASE_TICK same cycle -> IDLE, no NXM; TMO_LIMIT=0 -> NXM after first tick.
REQ-045 RESET at NXM_T step 2 -> IDLE next cycle, NXM_ACKN never asserted, NXM_ERR=0; 16 NXMs with CNT_W=4 -> NXM_COUNT=15.
